// File: rtl/iq_stream_scheduler_pkg.sv
// Shared state encodings and helpers for the I/Q stream scheduler.
package iq_stream_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_I    = 2'd1,
        O_Q    = 2'd2
    } out_state_t;

    // Settle counter must hold values 0..n; keep at least one bit when n is 0.
    function automatic int settle_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/iq_stream_scheduler_sync_fifo.sv
// Synchronous FIFO with flush; the caller owns all drop/overflow policy.
module iq_stream_scheduler_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // NOTE: storage is not reset; pointers alone define which entries are meaningful.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/iq_stream_scheduler.sv
// Drops the CIC start-up transient, queues {I,Q} pairs and serialises them
// as I then Q words on a valid/ready channel.
module iq_stream_scheduler
    import iq_stream_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int FIFO_DEPTH     = 8,
    parameter int SETTLE_SAMPLES = 4,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                          clk_in,
    input  logic                          RST,
    input  logic                          enable,
    input  logic                          sample_stb,
    input  logic [DATA_WIDTH-1:0]         I_IN,
    input  logic [DATA_WIDTH-1:0]         Q_IN,
    output logic [DATA_WIDTH-1:0]         word_out,
    output logic                          word_is_q,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = settle_cnt_width(SETTLE_SAMPLES);
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_SAMPLES);
    localparam logic [SW-1:0]        SETTLE_ONE  = SW'(1);
    localparam logic [LW-1:0]        LEVEL_ONE   = LW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    ctrl_state_t                 ctrl_state, ctrl_next;
    out_state_t                  out_state, out_next;
    logic [SW-1:0]               settle_cnt, settle_next, settle_inc;
    logic                        push_req;
    logic                        pop_req;
    logic                        drop;
    logic [2*DATA_WIDTH-1:0]     head;
    logic                        fifo_full;
    logic                        fifo_empty;

    assign settle_inc = settle_cnt + SETTLE_ONE;

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            ctrl_state <= IDLE;
            settle_cnt <= '0;
            out_state  <= O_IDLE;
        end else begin
            ctrl_state <= ctrl_next;
            settle_cnt <= settle_next;
            out_state  <= out_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ctrl_next   = ctrl_state;
        settle_next = settle_cnt;
        push_req    = 1'b0;
        if (!enable) begin
            ctrl_next   = IDLE;
            settle_next = '0;
        end else begin
            case (ctrl_state)
                IDLE: begin
                    settle_next = '0;
                    ctrl_next   = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
                end
                SETTLE: begin
                    if (sample_stb) begin
                        settle_next = settle_inc;
                        if (settle_inc == SETTLE_LAST) ctrl_next = RUN;
                    end
                end
                RUN:     push_req  = sample_stb;
                default: ctrl_next = IDLE;
            endcase
        end
    end

    always_comb begin
        out_next = out_state;
        pop_req  = 1'b0;
        if (!enable) begin
            out_next = O_IDLE;
        end else begin
            case (out_state)
                O_IDLE: if (!fifo_empty) out_next = O_I;
                O_I:    if (word_ready) out_next = O_Q;
                O_Q: begin
                    if (word_ready) begin
                        pop_req  = 1'b1;
                        out_next = (fifo_level > LEVEL_ONE) ? O_I : O_IDLE;
                    end
                end
                default: out_next = O_IDLE;
            endcase
        end
    end

    // The head entry only moves on pop, so the presented word holds through a stall.
    always_comb begin
        word_out = '0;
        case (out_state)
            O_I:     word_out = head[2*DATA_WIDTH-1:DATA_WIDTH];
            O_Q:     word_out = head[DATA_WIDTH-1:0];
            default: word_out = '0;
        endcase
    end

    assign word_valid = (out_state != O_IDLE);
    assign word_is_q  = (out_state == O_Q);
    assign drop       = push_req && fifo_full && !pop_req;

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (ovf_clr)                drop_count <= CNT_ONE;
            else if (drop_count != CNT_MAX) drop_count <= drop_count + CNT_ONE;
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    iq_stream_scheduler_sync_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .RST     (RST),
        .push    (push_req),
        .pop     (pop_req),
        .flush   (!enable),
        .wr_data ({I_IN, Q_IN}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_iq_stream_scheduler.sv
// Scoreboard bench for iq_stream_scheduler: expected words queued at stimulus
// time, compared as each word handshake completes.
module tb_iq_stream_scheduler;

    localparam int DW = 12;

    typedef struct packed {
        logic          is_q;
        logic [DW-1:0] data;
    } word_t;

    logic          clk_in = 1'b0;
    logic          RST;
    logic          enable;
    logic          sample_stb;
    logic [DW-1:0] I_IN;
    logic [DW-1:0] Q_IN;
    logic [DW-1:0] word_out;
    logic          word_is_q;
    logic          word_valid;
    logic          word_ready;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic          ovf_clr;
    logic [7:0]    drop_count;

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];

    always #5 clk_in = ~clk_in;

    iq_stream_scheduler #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (8),
        .SETTLE_SAMPLES (4),
        .CNT_WIDTH      (8)
    ) dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .enable     (enable),
        .sample_stb (sample_stb),
        .I_IN       (I_IN),
        .Q_IN       (Q_IN),
        .word_out   (word_out),
        .word_is_q  (word_is_q),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] i, input logic [DW-1:0] q, input bit keep);
        sample_stb = 1'b1;
        I_IN       = i;
        Q_IN       = q;
        if (keep) begin
            exp_q.push_back({1'b0, i});
            exp_q.push_back({1'b1, q});
        end
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || word_valid) && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        check(tag, exp_q.size(), 0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  word_valid, 0);
        check({tag, "_word"},   word_out,   0);
        check({tag, "_is_q"},   word_is_q,  0);
        check({tag, "_level"},  fifo_level, 0);
        check({tag, "_ovf"},    overflow,   0);
        check({tag, "_drops"},  drop_count, 0);
    endtask

    // Monitor: scoreboard compare on each handshake, and hold check across stalls.
    initial begin
        logic  prev_stall;
        logic  prev_en;
        word_t prev_word;
        word_t exp_w;
        prev_stall = 1'b0;
        prev_en    = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk_in);
            if (RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && prev_en) begin
                    check("hold_valid", word_valid, 1);
                    check("hold_word", {word_is_q, word_out}, prev_word);
                end
                if (word_valid && word_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", {word_is_q, word_out}, 32'hFFFF_FFFF);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("sb_word", {word_is_q, word_out}, exp_w);
                    end
                end
                prev_stall = word_valid && !word_ready;
                prev_en    = enable;
                prev_word  = {word_is_q, word_out};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        enable     = 1'b0;
        sample_stb = 1'b0;
        I_IN       = '0;
        Q_IN       = '0;
        word_ready = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) @(negedge clk_in);
        check_reset_outputs("reset");
        tick();
        RST = 1'b0;
        tick();

        // Settle discard: only strobes 5 and 6 reach the output.
        word_ready = 1'b1;
        enable     = 1'b1;
        tick();
        tick();
        for (int k = 1; k <= 6; k++) begin
            strobe(DW'(k), DW'(-k), k >= 5);
            tick();
        end
        wait_drain("t1_drain");

        // Latency from a single strobe with an idle output.
        sample_stb = 1'b1;
        I_IN       = 12'hA5A;
        Q_IN       = 12'h5A5;
        exp_q.push_back({1'b0, 12'hA5A});
        exp_q.push_back({1'b1, 12'h5A5});
        @(negedge clk_in);
        check("lat_n0_valid", word_valid, 0);
        @(posedge clk_in);
        #1;
        sample_stb = 1'b0;
        @(negedge clk_in);
        check("lat_n1_valid", word_valid, 0);
        @(negedge clk_in);
        check("lat_n2_valid", word_valid, 1);
        check("lat_n2_word", {word_is_q, word_out}, {1'b0, 12'hA5A});
        @(negedge clk_in);
        check("lat_n3_valid", word_valid, 1);
        check("lat_n3_word", {word_is_q, word_out}, {1'b1, 12'h5A5});
        @(negedge clk_in);
        check("lat_n4_valid", word_valid, 0);
        tick();

        // Stalled consumer: 10 strobes into depth 8.
        word_ready = 1'b0;
        for (int k = 0; k < 10; k++) strobe(DW'(12'h100 + k), DW'(12'h200 + k), k < 8);
        tick();
        check("t3_level", fifo_level, 8);
        check("t3_ovf", overflow, 1);
        check("t3_drops", drop_count, 2);
        repeat (5) tick();
        word_ready = 1'b1;
        wait_drain("t3_drain");
        check("t3_level_empty", fifo_level, 0);

        // Full FIFO, strobe coincident with the Q handshake.
        word_ready = 1'b0;
        for (int k = 0; k < 8; k++) strobe(DW'(12'h300 + k), DW'(12'h400 + k), 1'b1);
        tick();
        check("t4_full", fifo_level, 8);
        word_ready = 1'b1;
        tick();
        check("t4_in_q", word_is_q, 1);
        strobe(12'h3AA, 12'h4AA, 1'b1);
        word_ready = 1'b0;
        check("t4_level", fifo_level, 8);
        check("t4_drops", drop_count, 2);
        check("t4_ovf", overflow, 1);

        // Overflow clear racing a drop, then clear alone.
        ovf_clr = 1'b1;
        strobe(12'hBAD, 12'hBAD, 1'b0);
        ovf_clr = 1'b0;
        check("t5_ovf_race", overflow, 1);
        check("t5_drops_race", drop_count, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_ovf_clr", overflow, 0);
        check("t5_drops_clr", drop_count, 0);
        word_ready = 1'b1;
        wait_drain("t5_drain");

        // Disable during an O_Q stall flushes everything.
        word_ready = 1'b0;
        for (int k = 0; k < 3; k++) strobe(DW'(12'h500 + k), DW'(12'h600 + k), 1'b1);
        tick();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("t6_stall_valid", word_valid, 1);
        check("t6_stall_q", word_is_q, 1);
        check("t6_stall_level", fifo_level, 3);
        repeat (2) tick();
        enable = 1'b0;
        tick();
        check("t6_flush_valid", word_valid, 0);
        check("t6_flush_level", fifo_level, 0);
        exp_q.delete();

        // Asynchronous reset mid-run with queued data and overflow set.
        enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) strobe(DW'(12'h700 + k), DW'(12'h800 + k), 1'b0);
        tick();
        for (int k = 0; k < 10; k++) strobe(DW'(12'h900 + k), DW'(12'hA00 + k), k < 8);
        check("t6_pre_rst_level", fifo_level, 8);
        check("t6_pre_rst_ovf", overflow, 1);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("t6_async_rst");
        exp_q.delete();
        tick();
        RST    = 1'b0;
        enable = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
